// File: rtl/box_plotter_pkg.sv
// Shared screen geometry, coordinate widths, colour codes and drawer state type
// for the box_plotter rectangle drawer.
package box_plotter_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  localparam logic [X_W-1:0] X_MAX = 9'd319;
  localparam logic [Y_W-1:0] Y_MAX = 8'd239;

  localparam logic [2:0] COL_PUKE_GREEN  = 3'b000;
  localparam logic [2:0] COL_BLUE_PURPLE = 3'b001;
  localparam logic [2:0] COL_LIGHT_GREEN = 3'b010;
  localparam logic [2:0] COL_LIGHT_BLUE  = 3'b011;
  localparam logic [2:0] COL_ORANGE      = 3'b100;
  localparam logic [2:0] COL_PINK        = 3'b101;
  localparam logic [2:0] COL_YELLOW      = 3'b110;
  localparam logic [2:0] COL_WHITE       = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/box_plotter_clip.sv
// Combinational clipper: inclusive bottom-right corner of a box limited to the
// visible screen, plus a flag for boxes that draw nothing at all.
module box_clip
  import box_plotter_pkg::*;
(
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  output logic [8:0] xe,
  output logic [7:0] ye,
  output logic       empty
);

  logic [9:0] x_end;
  logic [9:0] y_end;

  // Ten bits hold the largest unclipped corner without wrapping; a zero extent
  // wraps here, but that case is flagged empty and the corner is then unused.
  always_comb begin
    x_end = {1'b0, x0} + {1'b0, width} - 10'd1;
    y_end = {2'b00, y0} + {2'b00, height} - 10'd1;
    xe    = (x_end > {1'b0, X_MAX}) ? X_MAX : x_end[8:0];
    ye    = (y_end > {2'b00, Y_MAX}) ? Y_MAX : y_end[7:0];
    empty = (width == 9'd0) || (height == 8'd0) ||
            (x0 > X_MAX) || (y0 > Y_MAX);
  end

endmodule

// File: rtl/box_plotter.sv
// Request-driven rectangle drawer feeding vga_adapter: one registered pixel
// write per cycle, filled or one-pixel outline, clipped to 320x240.
module box_plotter
  import box_plotter_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  input  logic [2:0] colour_in,
  input  logic       fill,
  output logic       busy,
  output logic       done,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  state_t     state_q, state_d;
  logic [8:0] bx0_q, bx0_d;
  logic [7:0] by0_q, by0_d;
  logic [8:0] bw_q, bw_d;
  logic [7:0] bh_q, bh_d;
  logic [2:0] bcol_q, bcol_d;
  logic       bfill_q, bfill_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] xe;
  logic [7:0] ye;
  logic       empty;
  logic       full_row;
  logic       last_pixel;

  box_clip u_clip (
    .x0     (bx0_q),
    .y0     (by0_q),
    .width  (bw_q),
    .height (bh_q),
    .xe     (xe),
    .ye     (ye),
    .empty  (empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      bx0_q    <= '0;
      by0_q    <= '0;
      bw_q     <= '0;
      bh_q     <= '0;
      bcol_q   <= '0;
      bfill_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx0_q    <= bx0_d;
      by0_q    <= by0_d;
      bw_q     <= bw_d;
      bh_q     <= bh_d;
      bcol_q   <= bcol_d;
      bfill_q  <= bfill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The x/y output registers double as the scan position: in DRAW they hold the
  // pixel currently on the bus and the next one is derived from them.
  always_comb begin
    state_d    = state_q;
    bx0_d      = bx0_q;
    by0_d      = by0_q;
    bw_d       = bw_q;
    bh_d       = bh_q;
    bcol_d     = bcol_q;
    bfill_d    = bfill_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    full_row   = bfill_q || (y_q == by0_q) || (y_q == ye);
    last_pixel = (x_q == xe) && (y_q == ye);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bx0_d   = x0;
          by0_d   = y0;
          bw_d    = width;
          bh_d    = height;
          bcol_d  = colour_in;
          bfill_d = fill;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (empty) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          x_d      = bx0_q;
          y_d      = by0_q;
          colour_d = bcol_q;
          plot_d   = 1'b1;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (last_pixel) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          plot_d = 1'b1;
          // Interior outline rows only touch the two side columns.
          if (full_row) begin
            if (x_q == xe) begin
              x_d = bx0_q;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
          end else if ((x_q == bx0_q) && (xe != bx0_q)) begin
            x_d = xe;
          end else begin
            x_d = bx0_q;
            y_d = y_q + 8'd1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: doc/box_plotter.md
Name: box_plotter

Overview:
- Upstream pixel-write generator for vga_adapter. Replaces hard-coded per-pixel state sequences with a request-driven drawer.
- Accepts one rectangle request: origin, width, height, colour and fill/outline mode.
- Emits one pixel write per cycle on x/y/colour/plot, wired directly to vga_adapter's colour, x, y and plot inputs.
- Screen is 320x240, 3-bit colour.

Parameters:
- SCREEN_W, 320, horizontal pixel count; legal x is 0..319.
- SCREEN_H, 240, vertical pixel count; legal y is 0..239.

Ports:
- clock  in  1  system clock, same clock as vga_adapter.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- x0  in  9  left column of box.
- y0  in  8  top row of box.
- width  in  9  box width in pixels; 0 is legal.
- height  in  8  box height in pixels; 0 is legal.
- colour_in  in  3  pixel colour for the whole box.
- fill  in  1  1 = solid box, 0 = one-pixel outline.
- busy  out  1  high while a request is being processed.
- done  out  1  one-cycle pulse when a request completes.
- x  out  9  pixel column to vga_adapter.
- y  out  8  pixel row to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  write enable to vga_adapter; x/y/colour are valid only while plot=1.

Behaviour:
- All outputs are registered.
- Reset values: x=0, y=0, colour=3'b000, plot=0, busy=0, done=0, state=IDLE. Reset clears these asynchronously.
- States: IDLE, LOAD, DRAW, FINISH.
- IDLE: start=1 latches x0, y0, width, height, colour_in and fill; go to LOAD; busy=1 next cycle. start while busy=1 is ignored; there is no queueing.
- LOAD (1 cycle): compute clipped bounds using 10-bit arithmetic.
  - xe = min(x0+width-1, 319); ye = min(y0+height-1, 239).
  - Empty box when width=0, height=0, x0>=320 or y0>=240. Empty boxes go directly to FINISH and produce no plot.
  - Otherwise load the scan counters cx=x0, cy=y0 and go to DRAW.
- DRAW: one pixel per cycle, row-major order (cy outer, cx inner).
  - Output x=cx, y=cy, colour=latched colour, plot=1.
  - Fill mode: cx steps +1 until xe, then cx=x0 and cy+1.
  - Outline mode, first row (cy=y0) and last row (cy=ye): step cx +1 as in fill.
  - Outline mode, interior rows: emit x0, then jump to xe. If xe=x0, emit one pixel only.
  - No plot=0 bubbles occur inside DRAW.
  - After the pixel at (xe, ye), go to FINISH.
- FINISH (1 cycle): plot=0, busy=0, done=1, then IDLE. done stays 0 in every other state.
- Timing: start sampled at edge T; LOAD during T+1; first pixel valid during T+2; N pixels occupy N consecutive cycles; done is in the cycle after the last pixel. An empty box gives done during T+2.
- Pixel counts:
  - Fill: (xe-x0+1)*(ye-y0+1).
  - Outline: 2*w' + 2*(h'-2), with w'/h' the clipped extents. Degenerate cases: h'=1 gives w'; w'=1 gives h'.
- x/y/colour hold their last values while plot=0.
- Reset asserted mid-request: the request is aborted with no further plots. After reset is released, the block is in IDLE and accepts a new start.

Decomposition:
- Shared include/package holds SCREEN_W/SCREEN_H, coordinate widths (9/8), and the colour codes: 3'b000 puke green, 001 blue/purple, 010 light green, 011 light blue, 100 orange, 101 pink, 110 yellow, 111 white.
- One combinational sub-module, box_clip: inputs x0/y0/width/height; outputs xe, ye, empty. Unit-testable on its own.

Test Plan:
- Fill, x0=100, y0=100, w=5, h=1, colour 111 -> plot=1 at (100..104, 100) on 5 consecutive cycles starting T+2; done=1 at T+7; busy high T+1..T+6.
- Fill, (10,20), w=3, h=2, colour 100 -> pixel order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21); 6 plots then done.
- Outline, (0,0), w=4, h=3 -> (0..3,0), (0,1), (3,1), (0..3,2); 10 plots in total; no pixel at (1,1) or (2,1).
- Clip, fill, (318,238), w=5, h=5 -> exactly (318,238), (319,238), (318,239), (319,239); never x>319 or y>239.
- Empty requests: w=0, then x0=400 -> no plot; done at T+2 each time; busy for 1 cycle only.
- resetn low at the 3rd pixel of a 10-pixel fill -> plot=0 and busy=0 immediately. start pulsed during busy is ignored (pixel stream unchanged). After reset release, a new 2x1 request draws 2 pixels.
